// File: rtl/decode_hazard_ctrl.sv
// ============================================================================
// Module  : decode_hazard_ctrl
// Brief   : Decode-stage interlock/forwarding controller with a shadow pipeline
//           of in-flight destinations, load-use stall and stall-cycle counter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module decode_hazard_ctrl #(
  parameter int POST_DEC_LD = 3,
  parameter int RADDR_W     = 5,
  parameter int RIP_ADDR    = 16,
  parameter int LOAD_READY  = 2,
  parameter int FLUSH_N     = 1
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   dec_valid,
  input  logic [RADDR_W-1:0]     dec_d,
  input  logic [RADDR_W-1:0]     dec_s,
  input  logic [RADDR_W-1:0]     dec_t,
  input  logic                   dec_use_d,
  input  logic                   dec_use_s,
  input  logic                   dec_use_t,
  input  logic                   dec_we,
  input  logic [RADDR_W-1:0]     dec_wreg,
  input  logic                   dec_is_load,
  input  logic                   ext_stall,
  input  logic                   flush,
  output logic                   stall_dec,
  output logic [POST_DEC_LD-1:0] fwd_d,
  output logic [POST_DEC_LD-1:0] fwd_s,
  output logic [POST_DEC_LD-1:0] fwd_t,
  output logic [31:0]            stall_cnt
);

  localparam int N = POST_DEC_LD;
  localparam logic [RADDR_W-1:0] RIP_IDX = RADDR_W'(RIP_ADDR);

  function automatic logic [N-1:0] build_ready_mask();
    logic [N-1:0] m;
    for (int i = 0; i < N; i++) m[i] = (i < LOAD_READY);
    return m;
  endfunction

  // Entries below LOAD_READY hold a load whose data is not yet available.
  localparam logic [N-1:0] READY_MASK = build_ready_mask();

  logic [N-1:0]         v_q, v_d;
  logic [N-1:0]         ld_q, ld_d;
  logic [RADDR_W-1:0]   wreg_q [N];
  logic [RADDR_W-1:0]   wreg_d [N];
  logic [31:0]          stall_cnt_q, stall_cnt_d;

  logic [RADDR_W-1:0]   op_idx [3];
  logic [2:0]           op_use;
  logic [N-1:0]         fwd_arr [3];
  logic                 hazard;
  logic                 issue;

  always_comb begin : p_match
    logic [N-1:0] match;
    logic [N-1:0] sel;
    logic         op_hz;
    op_idx[0] = dec_d;
    op_idx[1] = dec_s;
    op_idx[2] = dec_t;
    op_use    = {dec_use_t, dec_use_s, dec_use_d};
    hazard    = 1'b0;
    for (int x = 0; x < 3; x++) begin
      match = '0;
      for (int i = 0; i < N; i++) begin
        match[i] = op_use[x] & dec_valid & v_q[i] &
                   (wreg_q[i] == op_idx[x]) & (op_idx[x] != RIP_IDX);
      end
      // Isolate the lowest set bit: the youngest producer wins.
      sel        = match & (~match + {{(N-1){1'b0}}, 1'b1});
      op_hz      = |(sel & ld_q & READY_MASK);
      hazard     = hazard | op_hz;
      fwd_arr[x] = op_hz ? '0 : sel;
    end
  end

  assign stall_dec = rstn & (hazard | ext_stall);
  assign fwd_d     = rstn ? fwd_arr[0] : '0;
  assign fwd_s     = rstn ? fwd_arr[1] : '0;
  assign fwd_t     = rstn ? fwd_arr[2] : '0;
  assign stall_cnt = stall_cnt_q;
  assign issue     = dec_valid & ~stall_dec & ~flush;

  always_comb begin : p_next
    v_d  = v_q;
    ld_d = ld_q;
    for (int i = 0; i < N; i++) wreg_d[i] = wreg_q[i];
    if (!ext_stall) begin
      for (int i = 1; i < N; i++) begin
        v_d[i]    = v_q[i-1];
        ld_d[i]   = ld_q[i-1];
        wreg_d[i] = wreg_q[i-1];
      end
      // Non-writing instructions enter as bubbles so they never match.
      v_d[0]    = issue & dec_we;
      ld_d[0]   = issue & dec_we & dec_is_load;
      wreg_d[0] = dec_wreg;
    end
    if (flush) begin
      for (int i = 0; i < N; i++) begin
        if (i < FLUSH_N) v_d[i] = 1'b0;
      end
    end
    stall_cnt_d = stall_cnt_q;
    if (hazard && !ext_stall && !flush && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v_q         <= '0;
      ld_q        <= '0;
      stall_cnt_q <= '0;
      for (int i = 0; i < N; i++) wreg_q[i] <= '0;
    end else begin
      v_q         <= v_d;
      ld_q        <= ld_d;
      stall_cnt_q <= stall_cnt_d;
      for (int i = 0; i < N; i++) wreg_q[i] <= wreg_d[i];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_decode_hazard_ctrl.sv
// ============================================================================
// Module  : tb_decode_hazard_ctrl
// Brief   : Directed self-checking bench for decode_hazard_ctrl.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_decode_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        dec_valid;
  logic [4:0]  dec_d, dec_s, dec_t;
  logic        dec_use_d, dec_use_s, dec_use_t;
  logic        dec_we;
  logic [4:0]  dec_wreg;
  logic        dec_is_load;
  logic        ext_stall;
  logic        flush;
  logic        stall_dec;
  logic [2:0]  fwd_d, fwd_s, fwd_t;
  logic [31:0] stall_cnt;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  decode_hazard_ctrl dut (
    .clk(clk), .rstn(rstn), .dec_valid(dec_valid),
    .dec_d(dec_d), .dec_s(dec_s), .dec_t(dec_t),
    .dec_use_d(dec_use_d), .dec_use_s(dec_use_s), .dec_use_t(dec_use_t),
    .dec_we(dec_we), .dec_wreg(dec_wreg), .dec_is_load(dec_is_load),
    .ext_stall(ext_stall), .flush(flush), .stall_dec(stall_dec),
    .fwd_d(fwd_d), .fwd_s(fwd_s), .fwd_t(fwd_t), .stall_cnt(stall_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    dec_valid = 0; dec_d = 0; dec_s = 0; dec_t = 0;
    dec_use_d = 0; dec_use_s = 0; dec_use_t = 0;
    dec_we = 0; dec_wreg = 0; dec_is_load = 0;
    ext_stall = 0; flush = 0;
  endtask

  task automatic put_writer(input logic [4:0] r, input logic ld);
    clear_inputs();
    dec_valid = 1; dec_we = 1; dec_wreg = r; dec_is_load = ld;
  endtask

  task automatic drain();
    clear_inputs();
    repeat (3) tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    rstn = 0;
    ext_stall = 1;
    #1;
    tests++;
    if (stall_dec !== 1'b0 || fwd_d !== 3'b000 || stall_cnt !== 32'd0) begin
      failed++;
      $display("FAIL reset_outputs: stall=%b fwd_d=%b cnt=%0d, want 0/000/0", stall_dec, fwd_d, stall_cnt);
    end
    repeat (2) tick();
    rstn = 1;
    clear_inputs();
    dec_valid = 1; dec_s = 3; dec_use_s = 1;
    #1;
    tests++;
    if (fwd_s !== 3'b000 || stall_dec !== 1'b0 || stall_cnt !== 32'd0) begin
      failed++;
      $display("FAIL reset_head_s3: fwd_s=%b stall=%b cnt=%0d, want 000/0/0", fwd_s, stall_dec, stall_cnt);
    end
    tick();
  endtask

  task automatic test_alu_fwd();
    logic [2:0] exp_f [4];
    exp_f[0] = 3'b001; exp_f[1] = 3'b010; exp_f[2] = 3'b100; exp_f[3] = 3'b000;
    put_writer(5'd5, 1'b0);
    tick();
    clear_inputs();
    dec_valid = 1; dec_s = 5; dec_use_s = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      tests++;
      if (fwd_s !== exp_f[k] || stall_dec !== 1'b0) begin
        failed++;
        $display("FAIL alu_fwd_step%0d: fwd_s=%b stall=%b, want %b/0", k, fwd_s, stall_dec, exp_f[k]);
      end
      tick();
    end
  endtask

  task automatic test_load_use();
    put_writer(5'd7, 1'b1);
    tick();
    clear_inputs();
    dec_valid = 1; dec_t = 7; dec_use_t = 1;
    #1;
    tests++;
    if (stall_dec !== 1'b1 || fwd_t !== 3'b000 || stall_cnt !== 32'd0) begin
      failed++;
      $display("FAIL load_use_c0: stall=%b fwd_t=%b cnt=%0d, want 1/000/0", stall_dec, fwd_t, stall_cnt);
    end
    tick();
    tests++;
    if (stall_dec !== 1'b1 || fwd_t !== 3'b000 || stall_cnt !== 32'd1) begin
      failed++;
      $display("FAIL load_use_c1: stall=%b fwd_t=%b cnt=%0d, want 1/000/1", stall_dec, fwd_t, stall_cnt);
    end
    tick();
    tests++;
    if (stall_dec !== 1'b0 || fwd_t !== 3'b100 || stall_cnt !== 32'd2) begin
      failed++;
      $display("FAIL load_use_c2: stall=%b fwd_t=%b cnt=%0d, want 0/100/2", stall_dec, fwd_t, stall_cnt);
    end
    drain();
  endtask

  task automatic test_youngest_wins();
    put_writer(5'd4, 1'b1);
    tick();
    put_writer(5'd4, 1'b0);
    tick();
    clear_inputs();
    dec_valid = 1; dec_d = 4; dec_use_d = 1; dec_t = 4; dec_use_t = 1; dec_s = 3; dec_use_s = 1;
    #1;
    tests++;
    if (fwd_d !== 3'b001 || fwd_t !== 3'b001 || fwd_s !== 3'b000 || stall_dec !== 1'b0) begin
      failed++;
      $display("FAIL youngest_wins: fwd_d=%b fwd_t=%b fwd_s=%b stall=%b, want 001/001/000/0",
               fwd_d, fwd_t, fwd_s, stall_dec);
    end
    drain();
    // A non-writing instruction enters as a bubble and must never match.
    clear_inputs();
    dec_valid = 1; dec_wreg = 6;
    tick();
    dec_s = 6; dec_use_s = 1; dec_wreg = 0;
    #1;
    tests++;
    if (fwd_s !== 3'b000) begin
      failed++;
      $display("FAIL no_write_bubble: fwd_s=%b, want 000", fwd_s);
    end
    drain();
  endtask

  task automatic test_rip();
    put_writer(5'd16, 1'b1);
    tick();
    clear_inputs();
    dec_valid = 1; dec_s = 16; dec_use_s = 1; dec_d = 16; dec_use_d = 1;
    #1;
    tests++;
    if (fwd_s !== 3'b000 || fwd_d !== 3'b000 || stall_dec !== 1'b0) begin
      failed++;
      $display("FAIL rip_never_fwd: fwd_s=%b fwd_d=%b stall=%b, want 000/000/0", fwd_s, fwd_d, stall_dec);
    end
    drain();
  endtask

  task automatic test_ext_stall_flush();
    put_writer(5'd7, 1'b1);
    tick();
    clear_inputs();
    dec_valid = 1; dec_t = 7; dec_use_t = 1;
    ext_stall = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      tests++;
      if (stall_dec !== 1'b1 || fwd_t !== 3'b000 || stall_cnt !== 32'd2) begin
        failed++;
        $display("FAIL ext_stall_hold%0d: stall=%b fwd_t=%b cnt=%0d, want 1/000/2", k, stall_dec, fwd_t, stall_cnt);
      end
    end
    ext_stall = 0;
    tick();
    tests++;
    if (stall_dec !== 1'b1 || stall_cnt !== 32'd3) begin
      failed++;
      $display("FAIL ext_release_c1: stall=%b cnt=%0d, want 1/3", stall_dec, stall_cnt);
    end
    tick();
    tests++;
    if (stall_dec !== 1'b0 || fwd_t !== 3'b100 || stall_cnt !== 32'd4) begin
      failed++;
      $display("FAIL ext_release_c2: stall=%b fwd_t=%b cnt=%0d, want 0/100/4", stall_dec, fwd_t, stall_cnt);
    end
    drain();

    // Flush drops the head's issue and clears the youngest entry.
    put_writer(5'd8, 1'b0);
    tick();
    put_writer(5'd10, 1'b0);
    flush = 1;
    tick();
    clear_inputs();
    dec_valid = 1; dec_s = 8; dec_use_s = 1; dec_d = 10; dec_use_d = 1;
    #1;
    tests++;
    if (fwd_s !== 3'b010 || fwd_d !== 3'b000) begin
      failed++;
      $display("FAIL flush_no_issue: fwd_s=%b fwd_d=%b, want 010/000", fwd_s, fwd_d);
    end
    put_writer(5'd11, 1'b0);
    tick();
    clear_inputs();
    ext_stall = 1; flush = 1;
    tick();
    clear_inputs();
    dec_valid = 1; dec_s = 11; dec_use_s = 1; dec_d = 8; dec_use_d = 1;
    #1;
    tests++;
    if (fwd_s !== 3'b000 || fwd_d !== 3'b100) begin
      failed++;
      $display("FAIL flush_under_stall: fwd_s=%b fwd_d=%b, want 000/100", fwd_s, fwd_d);
    end
    drain();

    // A hazard cycle coinciding with flush is not counted.
    put_writer(5'd12, 1'b1);
    tick();
    clear_inputs();
    dec_valid = 1; dec_t = 12; dec_use_t = 1; flush = 1;
    tick();
    flush = 0;
    #1;
    tests++;
    if (stall_cnt !== 32'd4 || stall_dec !== 1'b1) begin
      failed++;
      $display("FAIL flush_no_count: cnt=%0d stall=%b, want 4/1", stall_cnt, stall_dec);
    end
    tick();
    tests++;
    if (stall_cnt !== 32'd5 || stall_dec !== 1'b0 || fwd_t !== 3'b100) begin
      failed++;
      $display("FAIL flush_then_count: cnt=%0d stall=%b fwd_t=%b, want 5/0/100", stall_cnt, stall_dec, fwd_t);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    put_writer(5'd5, 1'b0);
    tick();
    clear_inputs();
    dec_valid = 1; dec_s = 5; dec_use_s = 1;
    #1;
    tests++;
    if (fwd_s !== 3'b001) begin
      failed++;
      $display("FAIL pre_reset_fwd: fwd_s=%b, want 001", fwd_s);
    end
    rstn = 0;
    #1;
    tests++;
    if (fwd_s !== 3'b000 || stall_cnt !== 32'd0) begin
      failed++;
      $display("FAIL mid_reset: fwd_s=%b cnt=%0d, want 000/0", fwd_s, stall_cnt);
    end
    tick();
    rstn = 1;
    #1;
    tests++;
    if (fwd_s !== 3'b000 || stall_dec !== 1'b0) begin
      failed++;
      $display("FAIL post_reset: fwd_s=%b stall=%b, want 000/0", fwd_s, stall_dec);
    end
    drain();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_alu_fwd();
    test_load_use();
    test_youngest_wins();
    test_rip();
    test_ext_stall_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

`default_nettype wire
